// File: rtl/dispatch_queue_pkg.sv
// Shared types and constants for the ID -> reservation-station dispatch queue.
// Entry layout is common to the queue, its snoop logic and the testbench.
package dispatch_pkg;

  localparam int XLEN     = 32;
  localparam int TAG_W    = 5;
  localparam int UNIT_NUM = 4;
  localparam int UNIT_W   = $clog2(UNIT_NUM + 1);
  localparam int OP_W     = 6;

  localparam logic [TAG_W-1:0]  TAG_INVALID = '1;
  localparam logic [UNIT_W-1:0] EX_ERR_UNIT = UNIT_W'(UNIT_NUM);

  typedef struct packed {
    logic [UNIT_W-1:0]       ex_unit;
    logic [OP_W-1:0]         op;
    logic [1:2][TAG_W-1:0]   tag;
    logic [1:2][XLEN-1:0]    val;
    logic [TAG_W-1:0]        target;
    logic [XLEN-1:0]         pc;
    logic [XLEN-1:0]         offset;
    logic [2:0]              width;
  } dispatch_entry_t;

endpackage

// File: rtl/dispatch_queue_if.sv
// Bus bundle between ID, write-back broadcast and the dispatch queue.
// slave = queue side, master = producer/consumer side.
interface dispatch_queue_if #(
  parameter int DEPTH = 4
);
  import dispatch_pkg::*;

  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [UNIT_W-1:0]          in_ex_unit;
  logic [OP_W-1:0]            in_op;
  logic [TAG_W-1:0]           in_tag1;
  logic [TAG_W-1:0]           in_tag2;
  logic [XLEN-1:0]            in_val1;
  logic [XLEN-1:0]            in_val2;
  logic [TAG_W-1:0]           in_target;
  logic [XLEN-1:0]            in_pc;
  logic [XLEN-1:0]            in_offset;
  logic [2:0]                 in_width;
  logic                       wb_valid;
  logic [TAG_W-1:0]           wb_tag;
  logic [XLEN-1:0]            wb_val;
  logic [UNIT_NUM-1:0]        unit_full;
  logic                       out_valid;
  logic [UNIT_W-1:0]          out_ex_unit;
  logic [OP_W-1:0]            out_op;
  logic [TAG_W-1:0]           out_tag1;
  logic [TAG_W-1:0]           out_tag2;
  logic [XLEN-1:0]            out_val1;
  logic [XLEN-1:0]            out_val2;
  logic [TAG_W-1:0]           out_target;
  logic [XLEN-1:0]            out_pc;
  logic [XLEN-1:0]            out_offset;
  logic [2:0]                 out_width;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport slave (
    input  flush, in_valid, in_ex_unit, in_op,
    input  in_tag1, in_tag2, in_val1, in_val2,
    input  in_target, in_pc, in_offset, in_width,
    input  wb_valid, wb_tag, wb_val, unit_full,
    output in_ready, out_valid, out_ex_unit, out_op,
    output out_tag1, out_tag2, out_val1, out_val2,
    output out_target, out_pc, out_offset, out_width,
    output count
  );

  modport master (
    output flush, in_valid, in_ex_unit, in_op,
    output in_tag1, in_tag2, in_val1, in_val2,
    output in_target, in_pc, in_offset, in_width,
    output wb_valid, wb_tag, wb_val, unit_full,
    input  in_ready, out_valid, out_ex_unit, out_op,
    input  out_tag1, out_tag2, out_val1, out_val2,
    input  out_target, out_pc, out_offset, out_width,
    input  count
  );

endinterface

// File: rtl/dispatch_queue_operand_snoop.sv
// Resolves one tag/value operand against the write-back broadcast.
// An all-ones tag is already ready and can never be matched.
module operand_snoop
  import dispatch_pkg::*;
(
  input  logic [TAG_W-1:0] tag,
  input  logic [XLEN-1:0]  val,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [XLEN-1:0]  wb_val,
  output logic [TAG_W-1:0] snp_tag,
  output logic [XLEN-1:0]  snp_val
);

  logic hit;

  assign hit     = wb_valid & (tag != TAG_INVALID) & (tag == wb_tag);
  assign snp_tag = hit ? TAG_INVALID : tag;
  assign snp_val = hit ? wb_val : val;

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch FIFO between ID and the reservation stations.
// Define DISPATCH_EMPTY_BYPASS_EN for zero-latency pass-through when empty.
module dispatch_queue
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  dispatch_queue_if.slave dq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  dispatch_entry_t       mem [DEPTH];
  dispatch_entry_t       nxt [DEPTH];
  logic [1:2][TAG_W-1:0] ent_tag [DEPTH];
  logic [1:2][XLEN-1:0]  ent_val [DEPTH];
  logic [DEPTH-1:0]      vld;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         cnt;

  dispatch_entry_t       in_raw;
  dispatch_entry_t       in_snp;
  dispatch_entry_t       head;
  dispatch_entry_t       out_ent;
  logic [1:2][TAG_W-1:0] in_tag;
  logic [1:2][XLEN-1:0]  in_val;

  logic err;
  logic push;
  logic byp;
  logic head_vld;
  logic blocked;
  logic pop;
  logic pop_mem;
  logic store;

  always_comb begin
    in_raw         = '0;
    in_raw.ex_unit = dq.in_ex_unit;
    in_raw.op      = dq.in_op;
    in_raw.tag     = {dq.in_tag1, dq.in_tag2};
    in_raw.val     = {dq.in_val1, dq.in_val2};
    in_raw.target  = dq.in_target;
    in_raw.pc      = dq.in_pc;
    in_raw.offset  = dq.in_offset;
    in_raw.width   = dq.in_width;
  end

  for (genvar k = 1; k <= 2; k++) begin : g_in
    operand_snoop u_snp (
      .tag      (in_raw.tag[k]),
      .val      (in_raw.val[k]),
      .wb_valid (dq.wb_valid),
      .wb_tag   (dq.wb_tag),
      .wb_val   (dq.wb_val),
      .snp_tag  (in_tag[k]),
      .snp_val  (in_val[k])
    );
  end

  always_comb begin
    in_snp     = in_raw;
    in_snp.tag = in_tag;
    in_snp.val = in_val;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    for (genvar k = 1; k <= 2; k++) begin : g_op
      operand_snoop u_snp (
        .tag      (mem[i].tag[k]),
        .val      (mem[i].val[k]),
        .wb_valid (dq.wb_valid),
        .wb_tag   (dq.wb_tag),
        .wb_val   (dq.wb_val),
        .snp_tag  (ent_tag[i][k]),
        .snp_val  (ent_val[i][k])
      );
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i]     = mem[i];
      nxt[i].tag = ent_tag[i];
      nxt[i].val = ent_val[i];
    end
  end

  assign dq.in_ready = (cnt < CW'(DEPTH));
  assign err      = (dq.in_ex_unit == EX_ERR_UNIT);
  assign push     = dq.in_valid & dq.in_ready & ~dq.flush;
  assign head_vld = vld[rd_ptr];

`ifdef DISPATCH_EMPTY_BYPASS_EN
  assign byp = (cnt == '0) & push & ~err;
`else
  assign byp = 1'b0;
`endif

  // Head already carries this cycle's snoop, so RS sees same-cycle wb.
  assign head         = byp ? in_snp : nxt[rd_ptr];
  assign dq.out_valid = head_vld | byp;
  assign out_ent      = dq.out_valid ? head : '0;

  assign blocked = |(dq.unit_full & (UNIT_NUM'(1) << out_ent.ex_unit));
  assign pop     = dq.out_valid & ~blocked;
  assign pop_mem = pop & head_vld & ~dq.flush;
  assign store   = push & ~err & ~(pop & byp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      vld    <= '0;
    end else if (dq.flush) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      vld    <= '0;
    end else begin
      if (store) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_mem) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      cnt <= cnt + CW'(store) - CW'(pop_mem);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] <= nxt[i];
    end
    if (store) begin
      mem[wr_ptr] <= in_snp;
    end
  end

  assign dq.out_ex_unit = out_ent.ex_unit;
  assign dq.out_op      = out_ent.op;
  assign dq.out_tag1    = out_ent.tag[1];
  assign dq.out_tag2    = out_ent.tag[2];
  assign dq.out_val1    = out_ent.val[1];
  assign dq.out_val2    = out_ent.val[2];
  assign dq.out_target  = out_ent.target;
  assign dq.out_pc      = out_ent.pc;
  assign dq.out_offset  = out_ent.offset;
  assign dq.out_width   = out_ent.width;
  assign dq.count       = cnt;

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: directed vector table, async reset sequence,
// then random traffic against a queue-based reference model.
module tb_dispatch_queue;
  import dispatch_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int F     = 31;
`ifdef DISPATCH_EMPTY_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dispatch_queue_if #(.DEPTH(DEPTH)) dq ();

  dispatch_queue #(.DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .dq  (dq)
  );

  typedef struct {
    logic              iv;
    logic [UNIT_W-1:0] un;
    logic [TAG_W-1:0]  t1, t2;
    logic [XLEN-1:0]   v1, v2;
    logic              wv;
    logic [TAG_W-1:0]  wt;
    logic [XLEN-1:0]   wd;
    logic [3:0]        uf;
    logic              fl;
    logic              ev, er;
    logic [CW-1:0]     ec;
    logic [UNIT_W-1:0] eu;
    logic [TAG_W-1:0]  et1, et2;
    logic [XLEN-1:0]   ev1, ev2;
  } vec_t;

  vec_t            tv[$];
  dispatch_entry_t mq[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(
    int unsigned iv, int unsigned un, int unsigned t1, int unsigned t2,
    int unsigned v1, int unsigned v2, int unsigned wv, int unsigned wt,
    int unsigned wd, int unsigned uf, int unsigned fl, int unsigned ev,
    int unsigned er, int unsigned ec, int unsigned eu, int unsigned et1,
    int unsigned et2, int unsigned ev1, int unsigned ev2);
    vec_t r;
    r.iv = 1'(iv);   r.un = UNIT_W'(un);
    r.t1 = TAG_W'(t1); r.t2 = TAG_W'(t2);
    r.v1 = v1;       r.v2 = v2;
    r.wv = 1'(wv);   r.wt = TAG_W'(wt); r.wd = wd;
    r.uf = 4'(uf);   r.fl = 1'(fl);
    r.ev = 1'(ev);   r.er = 1'(er); r.ec = CW'(ec);
    r.eu = UNIT_W'(eu);
    r.et1 = TAG_W'(et1); r.et2 = TAG_W'(et2);
    r.ev1 = ev1;     r.ev2 = ev2;
    return r;
  endfunction

  task automatic check(string nm, logic [511:0] got, logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic iv, input dispatch_entry_t e,
                       input logic wv, input logic [TAG_W-1:0] wt,
                       input logic [XLEN-1:0] wd,
                       input logic [UNIT_NUM-1:0] uf, input logic fl);
    dq.in_valid   = iv;
    dq.in_ex_unit = e.ex_unit;
    dq.in_op      = e.op;
    dq.in_tag1    = e.tag[1];
    dq.in_tag2    = e.tag[2];
    dq.in_val1    = e.val[1];
    dq.in_val2    = e.val[2];
    dq.in_target  = e.target;
    dq.in_pc      = e.pc;
    dq.in_offset  = e.offset;
    dq.in_width   = e.width;
    dq.wb_valid   = wv;
    dq.wb_tag     = wt;
    dq.wb_val     = wd;
    dq.unit_full  = uf;
    dq.flush      = fl;
  endtask

  function automatic dispatch_entry_t dut_ent();
    dispatch_entry_t r;
    r.ex_unit = dq.out_ex_unit;
    r.op      = dq.out_op;
    r.tag[1]  = dq.out_tag1;
    r.tag[2]  = dq.out_tag2;
    r.val[1]  = dq.out_val1;
    r.val[2]  = dq.out_val2;
    r.target  = dq.out_target;
    r.pc      = dq.out_pc;
    r.offset  = dq.out_offset;
    r.width   = dq.out_width;
    return r;
  endfunction

  // Operand resolution rule: a waiting tag equal to a valid broadcast.
  function automatic dispatch_entry_t snp(dispatch_entry_t e, logic wv,
                                          logic [TAG_W-1:0] wt,
                                          logic [XLEN-1:0] wd);
    dispatch_entry_t r = e;
    if (wv && wt != TAG_INVALID) begin
      for (int k = 1; k <= 2; k++) begin
        if (r.tag[k] == wt) begin
          r.tag[k] = TAG_INVALID;
          r.val[k] = wd;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [TAG_W-1:0] rtag();
    if ($urandom_range(0, 2) == 0) return TAG_INVALID;
    return TAG_W'($urandom_range(0, 7));
  endfunction

  function automatic dispatch_entry_t rnd_ent();
    dispatch_entry_t e;
    e.ex_unit = ($urandom_range(0, 9) == 0) ? EX_ERR_UNIT
                : UNIT_W'($urandom_range(0, 3));
    e.op     = OP_W'($urandom);
    e.tag[1] = rtag();
    e.tag[2] = rtag();
    e.val[1] = $urandom;
    e.val[2] = $urandom;
    e.target = TAG_W'($urandom);
    e.pc     = $urandom;
    e.offset = $urandom;
    e.width  = 3'($urandom);
    return e;
  endfunction

  initial begin
    dispatch_entry_t  e, oe;
    logic             iv, wv, fl, ov, byp, pushed, popped;
    logic [TAG_W-1:0] wt;
    logic [XLEN-1:0]  wd;
    logic [3:0]       uf;
    logic [81:0]      g82, x82;
    logic [159:0]     g160, x160;
    int               sz;

`ifndef DISPATCH_EMPTY_BYPASS_EN
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,0,0, 0,1,0, 0,0,0,0,0));
    tv.push_back(mk(1,0,F,F,'h11,'h21, 0,0,0,0,0, 0,1,0, 0,0,0,0,0));
    tv.push_back(mk(1,0,F,F,'h12,'h22, 0,0,0,0,0, 1,1,1, 0,F,F,'h11,'h21));
    tv.push_back(mk(1,0,F,F,'h13,'h23, 0,0,0,0,0, 1,1,1, 0,F,F,'h12,'h22));
    tv.push_back(mk(1,0,F,F,'h14,'h24, 0,0,0,0,0, 1,1,1, 0,F,F,'h13,'h23));
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,0,0, 1,1,1, 0,F,F,'h14,'h24));
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,0,0, 0,1,0, 0,0,0,0,0));
    tv.push_back(mk(1,1,F,F,'h31,'h41, 0,0,0,2,0, 0,1,0, 0,0,0,0,0));
    tv.push_back(mk(1,1,F,F,'h32,'h42, 0,0,0,2,0, 1,1,1, 1,F,F,'h31,'h41));
    tv.push_back(mk(1,1,F,F,'h33,'h43, 0,0,0,2,0, 1,1,2, 1,F,F,'h31,'h41));
    tv.push_back(mk(1,1,F,F,'h34,'h44, 0,0,0,2,0, 1,1,3, 1,F,F,'h31,'h41));
    tv.push_back(mk(1,1,F,F,'h35,'h45, 0,0,0,2,0, 1,0,4, 1,F,F,'h31,'h41));
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,0,0, 1,0,4, 1,F,F,'h31,'h41));
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,0,0, 1,1,3, 1,F,F,'h32,'h42));
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,0,0, 1,1,2, 1,F,F,'h33,'h43));
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,0,0, 1,1,1, 1,F,F,'h34,'h44));
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,0,0, 0,1,0, 0,0,0,0,0));
    tv.push_back(mk(1,0,3,F,0,'h51,    0,0,0,1,0, 0,1,0, 0,0,0,0,0));
    tv.push_back(mk(0,0,F,F,0,0, 1,3,'hDEAD,1,0, 1,1,1, 0,F,F,'hDEAD,'h51));
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,1,0, 1,1,1, 0,F,F,'hDEAD,'h51));
    tv.push_back(mk(1,2,F,7,'h61,0,    0,0,0,0,0, 1,1,1, 0,F,F,'hDEAD,'h51));
    tv.push_back(mk(0,0,F,F,0,0,    1,7,'h55,0,0, 1,1,1, 2,F,F,'h61,'h55));
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,0,0, 0,1,0, 0,0,0,0,0));
    tv.push_back(mk(1,3,F,F,'h71,'h81, 0,0,0,8,0, 0,1,0, 0,0,0,0,0));
    tv.push_back(mk(1,3,F,F,'h72,'h82, 1,F,'hBAD,8,0, 1,1,1, 3,F,F,'h71,'h81));
    tv.push_back(mk(1,3,F,F,'h73,'h83, 0,0,0,8,0, 1,1,2, 3,F,F,'h71,'h81));
    tv.push_back(mk(1,3,F,F,'h74,'h84, 0,0,0,8,1, 1,1,3, 3,F,F,'h71,'h81));
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,0,0, 0,1,0, 0,0,0,0,0));
    tv.push_back(mk(1,4,F,F,'h91,'h92, 0,0,0,0,0, 0,1,0, 0,0,0,0,0));
    tv.push_back(mk(1,0,F,F,'ha1,'ha2, 0,0,0,1,0, 0,1,0, 0,0,0,0,0));
    tv.push_back(mk(1,4,F,F,'hb1,'hb2, 0,0,0,1,0, 1,1,1, 0,F,F,'ha1,'ha2));
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,0,0, 1,1,1, 0,F,F,'ha1,'ha2));
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,0,0, 0,1,0, 0,0,0,0,0));
`else
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,0,0, 0,1,0, 0,0,0,0,0));
    tv.push_back(mk(1,0,F,F,'h11,'h21, 0,0,0,0,0, 1,1,0, 0,F,F,'h11,'h21));
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,0,0, 0,1,0, 0,0,0,0,0));
    tv.push_back(mk(1,4,F,F,'h91,'h92, 0,0,0,0,0, 0,1,0, 0,0,0,0,0));
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,0,0, 0,1,0, 0,0,0,0,0));
    tv.push_back(mk(1,1,F,7,'h12,0,  1,7,'h55,2,0, 1,1,0, 1,F,F,'h12,'h55));
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,2,0, 1,1,1, 1,F,F,'h12,'h55));
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,0,0, 1,1,1, 1,F,F,'h12,'h55));
    tv.push_back(mk(0,0,F,F,0,0,       0,0,0,0,0, 0,1,0, 0,0,0,0,0));
`endif

    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk);
      #1;
      e        = '0;
      e.ex_unit = tv[i].un;
      e.op     = OP_W'(i);
      e.tag[1] = tv[i].t1;
      e.tag[2] = tv[i].t2;
      e.val[1] = tv[i].v1;
      e.val[2] = tv[i].v2;
      e.target = TAG_W'(i);
      e.pc     = 32'h100 + XLEN'(i * 4);
      e.width  = 3'd2;
      drive(tv[i].iv, e, tv[i].wv, tv[i].wt, tv[i].wd, tv[i].uf, tv[i].fl);
      @(negedge clk);
      g82 = {dq.out_valid, dq.in_ready, dq.count, dq.out_ex_unit,
             dq.out_tag1, dq.out_tag2, dq.out_val1, dq.out_val2};
      x82 = {tv[i].ev, tv[i].er, tv[i].ec, tv[i].eu,
             tv[i].et1, tv[i].et2, tv[i].ev1, tv[i].ev2};
      check($sformatf("vec%0d", i), 512'(g82), 512'(x82));
    end

    // Asynchronous reset in the middle of a blocked, partly filled queue.
    e = '0;
    e.ex_unit = 3'd2;
    e.tag[1]  = TAG_INVALID;
    e.tag[2]  = TAG_INVALID;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 drive(1'b1, e, 1'b0, '0, '0, 4'b0100, 1'b0);
    end
    @(posedge clk);
    #1 drive(1'b0, e, 1'b0, '0, '0, 4'b0100, 1'b0);
    #1 check("pre_rst", 512'({dq.out_valid, dq.count}),
             512'({1'b1, CW'(2)}));
    rst = 1'b1;
    #1 check("async_rst",
             512'({dq.out_valid, dq.in_ready, dq.count, dq.out_ex_unit}),
             512'({1'b0, 1'b1, CW'(0), UNIT_W'(0)}));
    @(posedge clk);
    #1 rst = 1'b0;

    for (int c = 0; c < 500; c++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 99) == 0);
      e   = rnd_ent();
      iv  = rst ? 1'b0 : 1'($urandom_range(0, 3) != 0);
      wv  = 1'($urandom_range(0, 1));
      wt  = ($urandom_range(0, 4) == 0) ? TAG_INVALID
            : TAG_W'($urandom_range(0, 7));
      wd  = $urandom;
      uf  = 4'($urandom) & 4'($urandom);
      fl  = ($urandom_range(0, 24) == 0);
      drive(iv, e, wv, wt, wd, uf, fl);
      @(negedge clk);
      if (rst) mq.delete();
      sz  = mq.size();
      byp = 1'b0;
      if (sz > 0) begin
        ov = 1'b1;
        oe = snp(mq[0], wv, wt, wd);
      end else if (BYP && iv && !fl && e.ex_unit != EX_ERR_UNIT) begin
        ov  = 1'b1;
        byp = 1'b1;
        oe  = snp(e, wv, wt, wd);
      end else begin
        ov = 1'b0;
        oe = '0;
      end
      g160 = {dq.out_valid, dq.in_ready, dq.count, dut_ent()};
      x160 = {ov, 1'(sz < DEPTH), CW'(sz), oe};
      check($sformatf("rand%0d", c), 512'(g160), 512'(x160));
      if (rst || fl) begin
        mq.delete();
      end else begin
        pushed = iv && (sz < DEPTH);
        popped = ov && !uf[oe.ex_unit[1:0]];
        foreach (mq[i]) mq[i] = snp(mq[i], wv, wt, wd);
        if (popped && !byp) void'(mq.pop_front());
        if (pushed && e.ex_unit != EX_ERR_UNIT && !(popped && byp))
          mq.push_back(snp(e, wv, wt, wd));
      end
    end

    @(posedge clk);
    #1 rst = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
